// File: rtl/subckt_pattern_gen.sv
// LFSR stimulus source with MISR response compaction for a sub-circuit under test.
// Define SUBCKT_PGEN_CMP_EN to add the golden_sig compare and mismatch flag.
module subckt_pattern_gen #(
    parameter int                 VEC_W  = 5,
    parameter logic [VEC_W-1:0]   TAPS   = 5'b10100,
    parameter logic [VEC_W-1:0]   SEED   = 5'b00001,
    parameter int                 CNT_W  = 10,
    parameter int                 LAT    = 2,
    parameter int                 MISR_W = 16,
    parameter logic [MISR_W-1:0]  POLY   = 16'h1021
) (
    input  logic              I1470_clk,
    input  logic              I1477_rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              hold,
    input  logic              resp_in,
    output logic [VEC_W-1:0]  vec_out,
    output logic              vec_valid,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature
`ifdef SUBCKT_PGEN_CMP_EN
    ,
    input  logic [MISR_W-1:0] golden_sig,
    output logic              mismatch
`endif
);

    localparam int DW = (LAT < 2) ? 1 : $clog2(LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    lfsr_q, lfsr_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic [LAT-1:0]      vvp_q, vvp_d;
    logic [MISR_W-1:0]   misr_q, misr_d;
    logic                accept;
    logic                issue;
    logic                fb;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        dcnt_d  = dcnt_q;
        misr_d  = misr_q;
        fb      = 1'b0;
        accept  = start && (state_q == S_IDLE || state_q == S_DONE);
        issue   = (state_q == S_RUN) && !hold;

        // vvp_q[0] is vec_valid; the top bit marks the capture edge
        vvp_d = (vvp_q << 1) | LAT'(issue);

        if (vvp_q[LAT-1]) begin
            fb     = misr_q[MISR_W-1] ^ resp_in;
            misr_d = {misr_q[MISR_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end

        if (issue) begin
            vec_d  = lfsr_q;
            lfsr_d = {lfsr_q[VEC_W-2:0], ^(lfsr_q & TAPS)};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_d == num_q) begin
                state_d = S_DRAIN;
                dcnt_d  = '0;
            end
        end

        if (state_q == S_DRAIN) begin
            dcnt_d = dcnt_q + 1'b1;
            if (dcnt_q == DW'(LAT - 1)) begin
                state_d = S_DONE;
            end
        end

        if (accept) begin
            lfsr_d  = SEED;
            cnt_d   = '0;
            misr_d  = '0;
            num_d   = num_vec;
            state_d = (num_vec == '0) ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            vec_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            dcnt_q  <= '0;
            vvp_q   <= '0;
            misr_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            dcnt_q  <= dcnt_d;
            vvp_q   <= vvp_d;
            misr_q  <= misr_d;
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = vvp_q[0];
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign signature = misr_q;

`ifdef SUBCKT_PGEN_CMP_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = mis_q;
        if (accept) begin
            mis_d = 1'b0;
        end
        // a zero-length restart from DONE also counts as a fresh entry
        if ((accept || state_q != S_DONE) && state_d == S_DONE) begin
            mis_d = (misr_d != golden_sig);
        end
    end

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign mismatch = mis_q;
`endif

endmodule

// File: tb/tb_subckt_pattern_gen.sv
// Self-checking bench for subckt_pattern_gen: directed table, corner sequences,
// and randomized runs against a per-vector reference model.
module tb_subckt_pattern_gen;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  num_vec = '0;
    logic        hold = 1'b0;
    logic        resp_in = 1'b0;
    logic [4:0]  vec_out;
    logic        vec_valid;
    logic        busy;
    logic        done;
    logic [15:0] signature;
`ifdef SUBCKT_PGEN_CMP_EN
    logic [15:0] golden_sig = '0;
    logic        mismatch;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] seq [31];

    always #5 clk = ~clk;

    subckt_pattern_gen dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .start     (start),
        .num_vec   (num_vec),
        .hold      (hold),
        .resp_in   (resp_in),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .busy      (busy),
        .done      (done),
        .signature (signature)
`ifdef SUBCKT_PGEN_CMP_EN
        ,
        .golden_sig(golden_sig),
        .mismatch  (mismatch)
`endif
    );

    typedef struct {
        int          n;
        logic [63:0] hmask;
        logic [63:0] rbits;
        int          restart;
        logic        chk;
        logic [15:0] esig;
        int          ebusy;
        logic [15:0] gold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fold(input logic [15:0] m, input logic r);
        logic f;
        f = m[15] ^ r;
        return {m[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    endfunction

    // One full run: vector i's response (rbits[i]) is driven in the cycle
    // before its capture edge; all other cycles get random noise.
    task automatic run(input vec_t t);
        int          e;
        int          issued;
        int          capidx;
        int          done_edge;
        int          busy_cnt;
        logic        dk;
        logic        done_exp;
        logic        exp_vv;
        logic        finished;
        logic        r;
        logic [4:0]  exp_vec;
        logic [15:0] m;
        int          capq [$];

        @(negedge clk);
        start   = 1'b1;
        num_vec = 10'(t.n);
        hold    = 1'b0;
        resp_in = 1'($urandom);
`ifdef SUBCKT_PGEN_CMP_EN
        golden_sig = t.gold;
`endif
        @(posedge clk);
        e = 0; issued = 0; capidx = 0; busy_cnt = 0;
        m = '0; exp_vv = 1'b0; finished = 1'b0; exp_vec = '0;
        dk = (t.n == 0);
        done_edge = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            done_exp = dk && (e >= done_edge);
`ifdef SUBCKT_PGEN_CMP_EN
            if (e == 0 && t.n != 0) chk("mismatch_clr", mismatch, 1'b0);
`endif
            chk("vec_valid", vec_valid, exp_vv);
            if (exp_vv) chk("vec_out", vec_out, exp_vec);
            chk("done", done, done_exp);
            if (busy) busy_cnt++;
            if (done_exp) begin
                finished = 1'b1;
                break;
            end
            start   = (e == t.restart);
            num_vec = start ? 10'd20 : 10'(t.n);
            hold    = (e < 64) ? t.hmask[e] : 1'($urandom);
            if (capq.size() > 0 && capq[0] == e + 1) begin
                r = t.rbits[capidx];
                capidx++;
                void'(capq.pop_front());
                m = fold(m, r);
            end else begin
                r = 1'($urandom);
            end
            resp_in = r;
            exp_vv = 1'b0;
            if (issued < t.n && !hold) begin
                exp_vec = seq[issued % 31];
                issued++;
                exp_vv = 1'b1;
                capq.push_back(e + 1 + LAT);
                if (issued == t.n) begin
                    dk = 1'b1;
                    done_edge = e + 1 + LAT;
                end
            end
            @(posedge clk);
            e++;
        end
        start = 1'b0;
        if (!finished) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            chk("busy_in_done", busy, 1'b0);
            chk("busy_cycles", busy_cnt, done_edge);
            if (t.ebusy >= 0) chk("busy_table", busy_cnt, t.ebusy);
            chk("sig_model", signature, m);
            if (t.chk) chk("sig_table", signature, t.esig);
`ifdef SUBCKT_PGEN_CMP_EN
            chk("mismatch", mismatch, m != t.gold);
`endif
            for (int j = 0; j < 3; j++) begin
                hold    = 1'($urandom);
                resp_in = 1'($urandom);
                @(negedge clk);
                chk("sig_frozen", signature, m);
                chk("done_held", done, 1'b1);
            end
        end
    endtask

    vec_t tab [9];

    initial begin
        logic [4:0] v;
        vec_t t;

        v = 5'b00001;
        for (int i = 0; i < 31; i++) begin
            seq[i] = v;
            v = {v[3:0], v[4] ^ v[2]};
        end

        tab[0] = '{6, 64'd0, 64'd0, -1, 1'b1, 16'h0000, 8, 16'h0000};
        tab[1] = '{1, 64'd0, 64'd1, -1, 1'b1, 16'h1021, 3, 16'h1021};
        tab[2] = '{1, 64'd0, 64'd1, -1, 1'b1, 16'h1021, 3, 16'h1020};
        tab[3] = '{0, 64'd0, 64'd0, -1, 1'b1, 16'h0000, 0, 16'h0000};
        tab[4] = '{4, 64'd0, 64'hB, -1, 1'b1, 16'hD1AD, 6, 16'hD1AD};
        tab[5] = '{4, 64'hC, 64'hB, -1, 1'b1, 16'hD1AD, 8, 16'h0000};
        tab[6] = '{5, 64'd0, 64'd0, 2, 1'b1, 16'h0000, 7, 16'h0000};
        tab[7] = '{3, 64'd0, 64'h5, -1, 1'b1, 16'h50A5, 5, 16'h50A5};
        tab[8] = '{2, 64'd0, 64'h3, -1, 1'b1, 16'h3063, 4, 16'h3063};

        #1 rst = 1'b1;
        #2;
        chk("rst_vec_out", vec_out, 5'd0);
        chk("rst_vec_valid", vec_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_signature", signature, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run(tab[i]);

        // reset while vector 3 is on the bus, with a capture already folded in
        @(negedge clk);
        start = 1'b1; num_vec = 10'd10; hold = 1'b0; resp_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_vec3", vec_out, seq[2]);
        chk("mid_sig", signature, 16'h1021);
        chk("mid_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vec_out", vec_out, 5'd0);
        chk("mid_rst_vec_valid", vec_valid, 1'b0);
        chk("mid_rst_sig", signature, 16'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        resp_in = 1'b0;

        run(tab[4]);

        for (int i = 0; i < 10; i++) begin
            t.n       = (i == 0) ? 35 : int'($urandom_range(0, 40));
            t.hmask   = {$urandom, $urandom} & {$urandom, $urandom};
            t.rbits   = {$urandom, $urandom};
            t.restart = int'($urandom_range(0, 12));
            t.chk     = 1'b0;
            t.esig    = '0;
            t.ebusy   = -1;
            t.gold    = 16'($urandom);
            run(t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/subckt_pattern_gen.md
Name: subckt_pattern_gen

Overview:
- LFSR-driven stimulus source for a Nt-node sub-circuit under test. Drives a VEC_W-bit pattern per cycle and compacts the returned single response bit into a MISR signature.
- Forms the transmit/compaction end paired with the sub-circuit receiver.
- Sits between the trojan-detection bench controller (start/num_vec/signature) and the sub-circuit's data inputs and output.

Parameters:
- VEC_W, 5, pattern width driven to sub-circuit data inputs
- TAPS, 5'b10100, LFSR feedback taps (bit set = bit XORed into feedback)
- SEED, 5'b00001, LFSR load value on start; nonzero
- CNT_W, 10, width of vector count
- LAT, 2, cycles from vec_out launch to matching resp_in sample (>=1)
- MISR_W, 16, signature width
- POLY, 16'h1021, MISR Galois polynomial

Ports:
- I1470_clk  in  1  clock, rising edge
- I1477_rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- num_vec  in  CNT_W  number of vectors; sampled with start
- hold  in  1  stall: freezes LFSR/count and inserts a bubble
- resp_in  in  1  sub-circuit output bit
- vec_out  out  VEC_W  registered pattern to sub-circuit
- vec_valid  out  1  vec_out carries a counted vector this cycle
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- signature  out  MISR_W  MISR contents; stable in DONE
- golden_sig  in  MISR_W  only with SUBCKT_PGEN_CMP_EN
- mismatch  out  1  only with SUBCKT_PGEN_CMP_EN

Behaviour:
- Reset, asynchronous: state=IDLE. vec_out=0, vec_valid=0, busy=0, done=0, signature=0, LFSR=SEED, count=0, valid pipeline cleared, mismatch=0.
- States:
  - IDLE -> start -> RUN, or -> DONE if num_vec==0.
  - RUN -> DRAIN after the num_vec-th vector issues.
  - DRAIN -> DONE after LAT cycles.
  - DONE -> start -> RUN, same rules as IDLE.
- start: on acceptance, LFSR=SEED, count=0, MISR=0, done drops next cycle. start in RUN or DRAIN is ignored.
- RUN, each cycle with hold=0:
  - vec_out<=LFSR, vec_valid<=1, count++.
  - LFSR<={LFSR[VEC_W-2:0], ^(LFSR&TAPS)}.
- RUN, hold=1: vec_valid<=0, vec_out holds its value, LFSR and count frozen.
- Valid pipeline: vec_valid delayed LAT cycles marks a capture cycle. Bubbles from hold propagate and are never captured.
- MISR update on capture cycle:
  - fb=MISR[MW-1]^resp_in.
  - MISR<={MISR[MW-2:0],1'b0}^(fb?POLY:0).
- DRAIN: vec_valid=0, hold ignored, captures continue. Exactly num_vec captures occur in total.
- signature continuously reflects MISR. In DONE it is frozen until the next accepted start.
- num_vec==0: DONE one cycle after start, signature=0.
- LFSR period with defaults is 31. num_vec>31 wraps the sequence; this is not an error.
- Reset mid-run aborts immediately to the reset values; a partial signature is discarded.

Optional Feature:
- Macro: SUBCKT_PGEN_CMP_EN.
- Defined:
  - golden_sig and mismatch ports exist.
  - On entry to DONE, mismatch<=(signature!=golden_sig). Held until the next accepted start or reset; cleared on start.
- Undefined:
  - golden_sig and mismatch ports are absent; no compare logic.

Test Plan:
- Reset mid-RUN: assert I1477_rst at vector 3 -> vec_out=0, vec_valid=0, signature=0 and busy=0 immediately (no clock edge needed).
- Sequence check: start, num_vec=6, hold=0, resp_in=0.
  - vec_out = 00001, 00010, 00100, 01001, 10010, 00101 on consecutive cycles with vec_valid=1.
  - busy high 8 cycles (6+LAT), then done=1, signature=16'h0000.
- Single response: num_vec=1, resp_in=1 only at the capture cycle (launch+2) -> signature=16'h1021.
- Hold bubble: num_vec=4, hold=1 for 2 cycles after vector 2 -> vectors 3 and 4 delayed 2 cycles, still 00100 and 01001. vec_valid low during hold; 4 captures; signature matches the no-hold run with the same per-vector responses.
- Boundaries:
  - num_vec=0 -> done=1 one cycle after start, signature=0.
  - start pulsed during RUN -> ignored; count unaffected.
- Compare (with SUBCKT_PGEN_CMP_EN): case 3 run with golden_sig=16'h1021 -> mismatch=0; golden_sig=16'h1020 -> mismatch=1 in DONE; next start -> mismatch=0.
